// File: rtl/bev_dram_bridge_if.sv
// Box-access channel from the beverage controller plus the AXI4-Lite DRAM port.
// The bridge uses the slave view; the controller/DRAM environment uses the master view.
interface bev_dram_bridge_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
);
    logic              C_in_valid;
    logic [7:0]        C_addr;
    logic              C_r_wb;
    logic [DATA_W-1:0] C_data_w;
    logic              C_out_valid;
    logic [DATA_W-1:0] C_data_r;

    logic              AR_VALID;
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_READY;
    logic              R_VALID;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_READY;
    logic              AW_VALID;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              AW_READY;
    logic              W_VALID;
    logic [DATA_W-1:0] W_DATA;
    logic              W_READY;
    logic              B_VALID;
    logic [1:0]        B_RESP;
    logic              B_READY;

    modport slave (
        input  C_in_valid, C_addr, C_r_wb, C_data_w,
        output C_out_valid, C_data_r,
        output AR_VALID, AR_ADDR, input AR_READY,
        input  R_VALID, R_DATA, R_RESP, output R_READY,
        output AW_VALID, AW_ADDR, input AW_READY,
        output W_VALID, W_DATA, input W_READY,
        input  B_VALID, B_RESP, output B_READY
    );

    modport master (
        output C_in_valid, C_addr, C_r_wb, C_data_w,
        input  C_out_valid, C_data_r,
        input  AR_VALID, AR_ADDR, output AR_READY,
        output R_VALID, R_DATA, R_RESP, input R_READY,
        input  AW_VALID, AW_ADDR, output AW_READY,
        input  W_VALID, W_DATA, output W_READY,
        output B_VALID, B_RESP, input B_READY
    );
endinterface

// File: rtl/bev_dram_bridge.sv
// Turns single-beat box read/write requests into AXI4-Lite transactions,
// one outstanding request at a time, with every handshake output registered.
module bev_dram_bridge #(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
    input logic              clk,
    input logic              rst_n,
    bev_dram_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] wdata_r;

    // Box n sits at BASE_ADDR + 8n; 255 boxes never overflow the 17-bit space.
    function automatic logic [ADDR_W-1:0] box_addr(input logic [7:0] box);
        box_addr = BASE_ADDR + ADDR_W'({box, 3'b000});
    endfunction

    // Request sequencing; every channel output is a Moore output of this FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            wdata_r         <= '0;
            bus.C_out_valid <= 1'b0;
            bus.C_data_r    <= '0;
            bus.AR_VALID    <= 1'b0;
            bus.AR_ADDR     <= '0;
            bus.R_READY     <= 1'b0;
            bus.AW_VALID    <= 1'b0;
            bus.AW_ADDR     <= '0;
            bus.W_VALID     <= 1'b0;
            bus.W_DATA      <= '0;
            bus.B_READY     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.C_in_valid) begin
                        wdata_r <= bus.C_data_w;
                        if (bus.C_r_wb) begin
                            bus.AR_VALID <= 1'b1;
                            bus.AR_ADDR  <= box_addr(bus.C_addr);
                            state_r      <= ST_AR;
                        end else begin
                            bus.AW_VALID <= 1'b1;
                            bus.AW_ADDR  <= box_addr(bus.C_addr);
                            state_r      <= ST_AW;
                        end
                    end
                end
                ST_AR: begin
                    if (bus.AR_READY) begin
                        bus.AR_VALID <= 1'b0;
                        bus.R_READY  <= 1'b1;
                        state_r      <= ST_R;
                    end
                end
                ST_R: begin
                    if (bus.R_VALID) begin
                        bus.R_READY     <= 1'b0;
                        bus.C_data_r    <= bus.R_DATA;
                        bus.C_out_valid <= 1'b1;
                        state_r         <= ST_DONE;
                    end
                end
                ST_AW: begin
                    // W may only open once the address handshake has completed.
                    if (bus.AW_READY) begin
                        bus.AW_VALID <= 1'b0;
                        bus.W_VALID  <= 1'b1;
                        bus.W_DATA   <= wdata_r;
                        state_r      <= ST_W;
                    end
                end
                ST_W: begin
                    if (bus.W_READY) begin
                        bus.W_VALID <= 1'b0;
                        bus.B_READY <= 1'b1;
                        state_r     <= ST_B;
                    end
                end
                ST_B: begin
                    if (bus.B_VALID) begin
                        bus.B_READY     <= 1'b0;
                        bus.C_out_valid <= 1'b1;
                        state_r         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.C_out_valid <= 1'b0;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    bus.C_out_valid <= 1'b0;
                    bus.AR_VALID    <= 1'b0;
                    bus.R_READY     <= 1'b0;
                    bus.AW_VALID    <= 1'b0;
                    bus.W_VALID     <= 1'b0;
                    bus.B_READY     <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
